adder_tree_acc: RTL
===================

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 Parameter BITS, default 8, unsigned width of each input lane.
REQ-002 Parameter NUM, default 32, number of input lanes; legal values are powers of two, 2..64; L = log2(NUM).
REQ-003 Parameter ACC_W, default 8, extra accumulator bits for multi-beat packets; W = BITS+L+ACC_W.
REQ-004 Parameter OUT_MODE, default 0, result mode: 0 = wrap to BITS, 1 = saturate to BITS, 2 = full width W.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 valid  input  1  an input beat is offered.
REQ-008 last  input  1  the offered beat ends the current packet.
REQ-009 data_in  input  NUM*BITS  lane i occupies bits [i*BITS +: BITS], unsigned.
REQ-010 ready  output  1  the block accepts a beat this cycle.
REQ-011 ready_out  input  1  the downstream accepts the result.
REQ-012 o  output  W  packet sum; bits above BITS are zero in modes 0 and 1.
REQ-013 ovf  output  1  overflow flag, qualified by valid_out.
REQ-014 valid_out  output  1  o and ovf hold a result.

Function
REQ-015 A beat SHALL be accepted when valid && ready.
REQ-016 ready SHALL equal ready_out || !valid_out.
REQ-017 The tree SHALL have L registered levels.
- Level k SHALL add pairs of level-(k-1) values.
- Each level SHALL widen by one bit, so there is no tree overflow.
REQ-018 The tree SHALL carry a valid bit and a last bit alongside the data at every level.
REQ-019 Stall rule: while valid_out && !ready_out, every pipeline register SHALL hold its value; otherwise all registers advance each cycle, and bubbles propagate as valid=0.
REQ-020 Accumulator stage, on a valid tree output:
- first beat of a packet: acc = sum;
- other beats: acc = acc + sum, computed at W+1 bits.
- A carry out of W bits SHALL set a sticky overflow bit.
REQ-021 When the accumulated beat has last=1, the output register SHALL load o/ovf and assert valid_out; the next valid beat starts a new packet.
REQ-022 Latency without stalls: valid_out SHALL rise exactly L+1 cycles after the clock edge that accepts the last beat.
REQ-023 Output conversion, with T the true packet sum:
- Mode 0: o = T mod 2^BITS; ovf = (T >= 2^BITS).
- Mode 1: o = min(T, 2^BITS-1); ovf = (T >= 2^BITS).
- Mode 2: o = T mod 2^W; ovf = sticky accumulator overflow.
REQ-024 valid_out SHALL clear on ready_out unless a new result loads in the same cycle; a load and a drain in the same cycle SHALL be lossless (back-to-back results).
REQ-025 o and ovf SHALL remain stable while valid_out && !ready_out.
REQ-026 Single-beat packets (last=1 on every beat) SHALL yield one result per beat at full throughput.
REQ-027 Inputs with valid=0 SHALL not affect any state; last is ignored when valid=0.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear the following, regardless of clk:
- all valid bits, acc, the sticky overflow bit and the packet-in-progress flag;
- o = 0, ovf = 0, valid_out = 0.
REQ-029 While in reset ready SHALL be 1; a packet partially accepted before reset is discarded; the first valid beat after release starts a new packet.

Verification
REQ-030 BITS=8, NUM=32, mode 0; a single beat with all lanes 1 and last=1 -> after 6 cycles valid_out=1, o=32, ovf=0.
REQ-031 Mode 0; single beat with all lanes 8 (T=256) -> o=0, ovf=1; the same beat in mode 1 -> o=255, ovf=1; in mode 2 -> o=256, ovf=0.
REQ-032 Mode 2, ACC_W=8; three beats of all lanes 255, last on the third beat -> one result, o=24480, ovf=0, 6 cycles after the third beat.
REQ-033 Mode 2, ACC_W=1, BITS=8, NUM=2; beats of 255,255 until the sum exceeds 2^10-1 -> ovf=1 and o = T mod 1024.
REQ-034 Single-beat packets every cycle with ready_out held low for 4 cycles mid-stream:
- ready=0 throughout the hold;
- o stable during the hold;
- no result lost or duplicated, and results arrive in order.
REQ-035 rst_n pulsed low between beat 1 and beat 2 of a 2-beat packet:
- outputs clear asynchronously;
- the post-reset packet sum excludes beat 1.

Source files
------------

// File: rtl/adder_tree_acc.sv
// Pipelined NUM-lane adder tree followed by a packet accumulator and an output
// conversion register; a single downstream stall holds the whole pipeline.
module adder_tree_acc #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned NUM      = 32,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned OUT_MODE = 0,
    localparam int unsigned L       = $clog2(NUM),
    localparam int unsigned W       = BITS + L + ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic                last,
    input  logic [NUM*BITS-1:0] data_in,
    output logic                ready,
    input  logic                ready_out,
    output logic [W-1:0]        o,
    output logic                ovf,
    output logic                valid_out
);

    localparam int unsigned TW = BITS + L;

    logic         w_adv;
    logic         r_valid_out;
    logic [W-1:0] r_o;
    logic         r_ovf;

    // Every register advances unless a finished result is waiting downstream.
    assign w_adv     = ready_out || !r_valid_out;
    assign ready     = w_adv;
    assign o         = r_o;
    assign ovf       = r_ovf;
    assign valid_out = r_valid_out;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned N  = NUM >> k;
        localparam int unsigned SW = BITS + k;

        logic [SW-2:0] w_in [2*N];
        logic          w_vld_in;
        logic          w_last_in;
        logic [SW-1:0] r_sum [N];
        logic          r_vld;
        logic          r_last;

        if (k == 1) begin : g_src
            for (genvar j = 0; j < 2*N; j++) begin : g_lane
                assign w_in[j] = data_in[j*BITS +: BITS];
            end
            assign w_vld_in  = valid;
            assign w_last_in = valid && last;
        end else begin : g_src
            for (genvar j = 0; j < 2*N; j++) begin : g_lane
                assign w_in[j] = g_lvl[k-1].r_sum[j];
            end
            assign w_vld_in  = g_lvl[k-1].r_vld;
            assign w_last_in = g_lvl[k-1].r_last;
        end

        // Data only moves on a valid beat so bubbles leave the sums untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
                for (int i = 0; i < int'(N); i++) begin
                    r_sum[i] <= '0;
                end
            end else if (w_adv) begin
                r_vld  <= w_vld_in;
                r_last <= w_last_in;
                if (w_vld_in) begin
                    for (int i = 0; i < int'(N); i++) begin
                        r_sum[i] <= SW'(w_in[2*i]) + SW'(w_in[2*i+1]);
                    end
                end
            end
        end
    end

    logic [TW-1:0] w_tree_sum;
    logic          w_tree_vld;
    logic          w_tree_last;
    logic [W:0]    w_acc_sum;
    logic [W-1:0]  r_acc;
    logic          r_acc_ovf;
    logic          r_acc_vld;
    logic          r_acc_last;
    logic          r_in_pkt;

    assign w_tree_sum  = g_lvl[L].r_sum[0];
    assign w_tree_vld  = g_lvl[L].r_vld;
    assign w_tree_last = g_lvl[L].r_last;

    always_comb begin
        w_acc_sum = (W+1)'(w_tree_sum);
        if (r_in_pkt) begin
            w_acc_sum = w_acc_sum + (W+1)'(r_acc);
        end
    end

    // Packet accumulator; the carry out of W bits is kept sticky per packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            r_acc_vld  <= 1'b0;
            r_acc_last <= 1'b0;
            r_in_pkt   <= 1'b0;
        end else if (w_adv) begin
            r_acc_vld  <= w_tree_vld;
            r_acc_last <= w_tree_last;
            if (w_tree_vld) begin
                r_acc     <= w_acc_sum[W-1:0];
                r_acc_ovf <= (r_in_pkt && r_acc_ovf) || w_acc_sum[W];
                r_in_pkt  <= !w_tree_last;
            end
        end
    end

    logic         w_big;
    logic [W-1:0] w_o_conv;
    logic         w_ovf_conv;

    assign w_big = r_acc_ovf || (r_acc[W-1:BITS] != '0);

    always_comb begin
        w_o_conv   = W'(r_acc[BITS-1:0]);
        w_ovf_conv = w_big;
        if (OUT_MODE == 1 && w_big) begin
            w_o_conv = W'({BITS{1'b1}});
        end else if (OUT_MODE == 2) begin
            w_o_conv   = r_acc;
            w_ovf_conv = r_acc_ovf;
        end
    end

    // A load and a drain in the same cycle simply replace the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o         <= '0;
            r_ovf       <= 1'b0;
            r_valid_out <= 1'b0;
        end else if (w_adv) begin
            if (r_acc_vld && r_acc_last) begin
                r_o         <= w_o_conv;
                r_ovf       <= w_ovf_conv;
                r_valid_out <= 1'b1;
            end else begin
                r_valid_out <= 1'b0;
            end
        end
    end

endmodule
